// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - FP register file write-back arbiter with pending-write scoreboard
// Picks the FPU or load/move result each cycle, registers it onto the single write port.
module fp_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [4:0]        issue_dst,
   output logic              issue_ready,
   input  logic [4:0]        rd_reg1,
   input  logic [4:0]        rd_reg2,
   output logic              raw_hazard,
   input  logic              fpu_valid,
   input  logic [4:0]        fpu_reg,
   input  logic [DATA_W-1:0] fpu_data,
   output logic              fpu_ready,
   input  logic              mem_valid,
   input  logic [4:0]        mem_reg,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              wr_en,
   output logic [4:0]        wr_reg,
   output logic [DATA_W-1:0] wr_data,
   output logic [31:0]       busy_vec
);

   logic              r_last_mem;
   logic              r_wr_en;
   logic [4:0]        r_wr_reg;
   logic [DATA_W-1:0] r_wr_data;
   logic [31:0]       r_busy;

   logic              w_fpu_gnt;
   logic              w_mem_gnt;
   logic              w_issue_ok;
   logic [31:0]       w_set;
   logic [31:0]       w_clr;

   // On a tie the FPU wins unless round-robin says it won last time.
   assign w_fpu_gnt  = fpu_valid & (~mem_valid | ~RR_EN | r_last_mem);
   assign w_mem_gnt  = mem_valid & (~fpu_valid | (RR_EN & ~r_last_mem));
   assign w_issue_ok = issue_valid & ~r_busy[issue_dst];
   assign w_set      = w_issue_ok ? (32'd1 << issue_dst) : 32'd0;
   assign w_clr      = r_wr_en ? (32'd1 << r_wr_reg) : 32'd0;

   assign fpu_ready   = w_fpu_gnt;
   assign mem_ready   = w_mem_gnt;
   assign issue_ready = ~r_busy[issue_dst];
   assign raw_hazard  = r_busy[rd_reg1] | r_busy[rd_reg2];
   assign wr_en       = r_wr_en;
   assign wr_reg      = r_wr_reg;
   assign wr_data     = r_wr_data;
   assign busy_vec    = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_mem <= 1'b1;
         r_wr_en    <= 1'b0;
         r_wr_reg   <= 5'd0;
         r_wr_data  <= '0;
         r_busy     <= 32'd0;
      end else begin
         r_wr_en <= w_fpu_gnt | w_mem_gnt;
         if (w_fpu_gnt) begin
            r_last_mem <= 1'b0;
            r_wr_reg   <= fpu_reg;
            r_wr_data  <= fpu_data;
         end else if (w_mem_gnt) begin
            r_last_mem <= 1'b1;
            r_wr_reg   <= mem_reg;
            r_wr_data  <= mem_data;
         end
         // A new issue to the register being retired keeps it pending.
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - scoreboard bench for fp_wb_arbiter
module tb_fp_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_dst;
   logic        issue_ready;
   logic [4:0]  rd_reg1, rd_reg2;
   logic        raw_hazard;
   logic        fpu_valid;
   logic [4:0]  fpu_reg;
   logic [31:0] fpu_data;
   logic        fpu_ready;
   logic        mem_valid;
   logic [4:0]  mem_reg;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        wr_en;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [31:0] busy_vec;

   logic        issue_ready_fp, raw_hazard_fp, fpu_ready_fp, mem_ready_fp, wr_en_fp;
   logic [4:0]  wr_reg_fp;
   logic [31:0] wr_data_fp, busy_vec_fp;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   bit          m_busy[32];
   bit          m_last_fpu;
   bit          m_wr_pend;
   logic [4:0]  m_wr_reg;
   bit          g_fpu, g_mem;

   always #5 clk = ~clk;

   fp_wb_arbiter #(.DATA_W(32), .RR_EN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
      .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .raw_hazard(raw_hazard),
      .fpu_valid(fpu_valid), .fpu_reg(fpu_reg), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
      .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .busy_vec(busy_vec)
   );

   fp_wb_arbiter #(.DATA_W(32), .RR_EN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready_fp),
      .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .raw_hazard(raw_hazard_fp),
      .fpu_valid(fpu_valid), .fpu_reg(fpu_reg), .fpu_data(fpu_data), .fpu_ready(fpu_ready_fp),
      .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready_fp),
      .wr_en(wr_en_fp), .wr_reg(wr_reg_fp), .wr_data(wr_data_fp), .busy_vec(busy_vec_fp)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] busy_word();
      logic [31:0] w;
      for (int i = 0; i < 32; i++) w[i] = m_busy[i];
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_last_fpu = 1'b0;
      m_wr_pend  = 1'b0;
      m_wr_reg   = 5'd0;
      exp_q.delete();
   endtask

   // Scoreboard monitor: every write-port cycle must match the oldest granted request.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
         if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("wr_reg", wr_reg, mon_e.r);
            chk("wr_data", wr_data, mon_e.d);
         end
      end
   end

   task automatic cycle();
      bit          gf, gm, acc;
      @(negedge clk);
      if (fpu_valid && mem_valid) begin
         gf = !m_last_fpu;
         gm = m_last_fpu;
      end else begin
         gf = fpu_valid;
         gm = mem_valid;
      end
      acc = issue_valid && !m_busy[issue_dst];
      chk("fpu_ready", fpu_ready, gf);
      chk("mem_ready", mem_ready, gm);
      chk("fp_fpu_ready", fpu_ready_fp, fpu_valid);
      chk("fp_mem_ready", mem_ready_fp, mem_valid && !fpu_valid);
      chk("issue_ready", issue_ready, !m_busy[issue_dst]);
      chk("raw_hazard", raw_hazard, m_busy[rd_reg1] || m_busy[rd_reg2]);
      chk("busy_vec", busy_vec, busy_word());
      chk("wr_en", wr_en, m_wr_pend);
      if (gf) begin
         exp_q.push_back('{r: fpu_reg, d: fpu_data});
         m_last_fpu = 1'b1;
      end else if (gm) begin
         exp_q.push_back('{r: mem_reg, d: mem_data});
         m_last_fpu = 1'b0;
      end
      if (m_wr_pend) m_busy[m_wr_reg] = 1'b0;
      if (acc) m_busy[issue_dst] = 1'b1;
      m_wr_pend = gf || gm;
      if (gf) m_wr_reg = fpu_reg;
      else if (gm) m_wr_reg = mem_reg;
      g_fpu = gf;
      g_mem = gm;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; fpu_valid = 0; mem_valid = 0;
   endtask

   initial begin
      rst_n = 0;
      issue_valid = 0; issue_dst = 0; rd_reg1 = 0; rd_reg2 = 0;
      fpu_valid = 0; fpu_reg = 0; fpu_data = 0;
      mem_valid = 0; mem_reg = 0; mem_data = 0;
      model_reset();
      #3;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_reg", wr_reg, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy_vec, 0);
      @(posedge clk); #1;
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         issue_dst = 5'(i * 9);
         rd_reg1 = 5'(i * 7); rd_reg2 = 5'(31 - i);
         cycle();
      end

      // single FPU write
      issue_valid = 1; issue_dst = 5;
      cycle();
      issue_valid = 0;
      chk("single_busy_set", busy_vec, 32'h0000_0020);
      fpu_valid = 1; fpu_reg = 5; fpu_data = 32'h3F80_0000;
      cycle();
      fpu_valid = 0;
      cycle();
      chk("single_busy_clr", busy_vec, 32'h0);

      // contention: both sources request every cycle
      fpu_valid = 1; fpu_reg = 1; fpu_data = $urandom;
      mem_valid = 1; mem_reg = 2; mem_data = $urandom;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (g_fpu) fpu_data = $urandom;
         if (g_mem) mem_data = $urandom;
      end
      idle();
      cycle(); cycle();

      // hazards on reg 3
      issue_valid = 1; issue_dst = 3;
      cycle();
      rd_reg1 = 3; rd_reg2 = 0;
      #1;
      chk("raw_set", raw_hazard, 1);
      chk("waw_block", issue_ready, 0);
      cycle();
      chk("waw_busy_keep", busy_vec, 32'h0000_0008);
      issue_valid = 0;
      fpu_valid = 1; fpu_reg = 3; fpu_data = 32'h4000_0000;
      cycle();
      fpu_valid = 0;
      cycle();
      chk("raw_clear", raw_hazard, 0);
      chk("issue_ok", issue_ready, 1);

      // set and clear of reg 7 in the same cycle
      fpu_valid = 1; fpu_reg = 7; fpu_data = 32'hC0DE_0007;
      cycle();
      fpu_valid = 0;
      issue_valid = 1; issue_dst = 7;
      cycle();
      issue_valid = 0;
      chk("set_wins", busy_vec[7], 1);
      issue_dst = 7;
      cycle();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_dst = 5'($urandom_range(0, 7));
         rd_reg1 = 5'($urandom_range(0, 7));
         rd_reg2 = 5'($urandom_range(0, 7));
         if (!fpu_valid || g_fpu) begin
            fpu_valid = $urandom_range(0, 1);
            fpu_reg = 5'($urandom_range(0, 7));
            fpu_data = $urandom;
         end
         if (!mem_valid || g_mem) begin
            mem_valid = $urandom_range(0, 1);
            mem_reg = 5'($urandom_range(0, 7));
            mem_data = $urandom;
         end
         cycle();
      end
      idle();
      cycle(); cycle();

      // reset while a write is in flight
      issue_valid = 1; issue_dst = 9;
      cycle();
      issue_valid = 0;
      fpu_valid = 1; fpu_reg = 9; fpu_data = 32'h1234_5678;
      cycle();
      fpu_valid = 0;
      #2;
      rst_n = 0;
      #1;
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_busy", busy_vec, 0);
      model_reset();
      #2;
      rst_n = 1;
      @(posedge clk); #1;
      cycle(); cycle();
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
